// File: rtl/game_flow_sequencer.sv
// Top-level Bomber Man game-state sequencer: start/level-load/play/death/clear/game-over/win.
// Owns lives, level number and the player invulnerability window fed back to collision logic.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | power-up / reset; waiting for a start key edge
// LOAD      | single cycle; board and enemies reinitialise, invuln reloads
// PLAY      | game running; hits, door and power-ups are evaluated
// DYING     | frozen after an accepted hit for DYING_FRAMES frames
// CLEAR     | frozen after a level clear for CLEAR_FRAMES frames
// GAME_OVER | out of lives; values hold until a new start edge
// WIN       | last level cleared; values hold until a new start edge
module game_flow_sequencer #(
  parameter int unsigned LIVES_INIT    = 3,
  parameter int unsigned LEVEL_MAX     = 8,
  parameter int unsigned INVULN_FRAMES = 60,
  parameter int unsigned DYING_FRAMES  = 45,
  parameter int unsigned CLEAR_FRAMES  = 90
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       start_key,
  input  logic       player_hit,
  input  logic       player_door_idol,
  input  logic       collision_player_powerUp,
  input  logic [1:0] enemies_remaining,
  output logic [2:0] game_state,
  output logic [2:0] lives,
  output logic [3:0] level,
  output logic       player_invulnerable,
  output logic       freeze_motion,
  output logic       level_load,
  output logic       life_lost
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_PLAY      = 3'd2,
    S_DYING     = 3'd3,
    S_CLEAR     = 3'd4,
    S_GAME_OVER = 3'd5,
    S_WIN       = 3'd6
  } state_t;

  localparam logic [2:0] LIVES_INIT_C = 3'(LIVES_INIT);
  localparam logic [3:0] LEVEL_MAX_C  = 4'(LEVEL_MAX);
  localparam logic [7:0] INVULN_C     = 8'(INVULN_FRAMES);
  localparam logic [7:0] DYING_C      = 8'(DYING_FRAMES);
  localparam logic [7:0] CLEAR_C      = 8'(CLEAR_FRAMES);

  state_t     state_q, state_d;
  logic [2:0] lives_q, lives_d;
  logic [3:0] level_q, level_d;
  logic [7:0] timer_q, timer_d;
  logic [7:0] invuln_q, invuln_d;
  logic       key_q, key_d;
  logic       rise_q, rise_d;
  logic       life_lost_q, life_lost_d;

  logic hit_ok;
  logic door_ok;

  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    level_d     = level_q;
    timer_d     = timer_q;
    invuln_d    = invuln_q;
    key_d       = start_key;
    rise_d      = start_key & ~key_q;
    life_lost_d = 1'b0;

    hit_ok  = player_hit && (invuln_q == 8'd0);
    door_ok = player_door_idol && (enemies_remaining == 2'd0);

    case (state_q)
      S_IDLE, S_GAME_OVER, S_WIN: begin
        if (rise_q) begin
          lives_d = LIVES_INIT_C;
          level_d = 4'd1;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        invuln_d = INVULN_C;
        state_d  = S_PLAY;
      end

      S_PLAY: begin
        // A hit outranks a simultaneous valid door contact.
        if (hit_ok) begin
          lives_d     = lives_q - 3'd1;
          life_lost_d = 1'b1;
          timer_d     = DYING_C;
          state_d     = S_DYING;
        end else if (door_ok) begin
          timer_d = CLEAR_C;
          state_d = S_CLEAR;
        end

        if (collision_player_powerUp) begin
          invuln_d = INVULN_C;
        end else if (startOfFrame && (invuln_q != 8'd0)) begin
          invuln_d = invuln_q - 8'd1;
        end
      end

      S_DYING: begin
        if (startOfFrame && (timer_q != 8'd0)) begin
          timer_d = timer_q - 8'd1;
          if (timer_q == 8'd1) begin
            state_d = (lives_q == 3'd0) ? S_GAME_OVER : S_LOAD;
          end
        end
      end

      S_CLEAR: begin
        if (startOfFrame && (timer_q != 8'd0)) begin
          timer_d = timer_q - 8'd1;
          if (timer_q == 8'd1) begin
            if (level_q == LEVEL_MAX_C) begin
              state_d = S_WIN;
            end else begin
              level_d = level_q + 4'd1;
              state_d = S_LOAD;
            end
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= S_IDLE;
      lives_q     <= 3'd0;
      level_q     <= 4'd0;
      timer_q     <= 8'd0;
      invuln_q    <= 8'd0;
      key_q       <= 1'b0;
      rise_q      <= 1'b0;
      life_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      level_q     <= level_d;
      timer_q     <= timer_d;
      invuln_q    <= invuln_d;
      key_q       <= key_d;
      rise_q      <= rise_d;
      life_lost_q <= life_lost_d;
    end
  end

  assign game_state          = state_q;
  assign lives               = lives_q;
  assign level               = level_q;
  assign player_invulnerable = (invuln_q != 8'd0);
  assign freeze_motion       = (state_q != S_PLAY);
  assign level_load          = (state_q == S_LOAD);
  assign life_lost           = life_lost_q;

endmodule

// File: tb/tb_game_flow_sequencer.sv
// Directed bench for game_flow_sequencer with LEVEL_MAX=2 so both clear and win paths are short.
module tb_game_flow_sequencer;

  logic       clk = 1'b0;
  logic       resetN = 1'b1;
  logic       sof = 1'b0;
  logic       start_key = 1'b0;
  logic       player_hit = 1'b0;
  logic       door = 1'b0;
  logic       pup = 1'b0;
  logic [1:0] enemies = 2'd1;

  logic [2:0] game_state;
  logic [2:0] lives;
  logic [3:0] level;
  logic       player_invulnerable;
  logic       freeze_motion;
  logic       level_load;
  logic       life_lost;

  int checks = 0;
  int errors = 0;
  int lost_cnt = 0;

  game_flow_sequencer #(
    .LIVES_INIT(3), .LEVEL_MAX(2), .INVULN_FRAMES(60), .DYING_FRAMES(45), .CLEAR_FRAMES(90)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .startOfFrame(sof),
    .start_key(start_key),
    .player_hit(player_hit),
    .player_door_idol(door),
    .collision_player_powerUp(pup),
    .enemies_remaining(enemies),
    .game_state(game_state),
    .lives(lives),
    .level(level),
    .player_invulnerable(player_invulnerable),
    .freeze_motion(freeze_motion),
    .level_load(level_load),
    .life_lost(life_lost)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (life_lost === 1'b1) lost_cnt++;

  typedef struct {
    logic       start, hit, door, pup;
    logic [1:0] enem;
    logic [2:0] st, lv;
    logic [3:0] lvl;
    logic       inv, frz, ld, lost;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      sof = 1'b1; cyc();
      sof = 1'b0; cyc();
    end
  endtask

  task automatic last_frame();
    sof = 1'b1; cyc(); sof = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, 32'(game_state), 0);
    chk({tag, "_lives"}, 32'(lives), 0);
    chk({tag, "_level"}, 32'(level), 0);
    chk({tag, "_invul"}, 32'(player_invulnerable), 0);
    chk({tag, "_freeze"}, 32'(freeze_motion), 1);
    chk({tag, "_load"}, 32'(level_load), 0);
    chk({tag, "_lost"}, 32'(life_lost), 0);
  endtask

  initial begin
    int loads;
    int load_at;

    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 3'd2, 3'd3, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 3'd2, 3'd3, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 3'd2, 3'd3, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 3'd2, 3'd3, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 3'd2, 3'd3, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 3'd4, 3'd3, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0};

    #1 resetN = 1'b0;
    repeat (3) cyc();
    chk_reset("rst");
    resetN = 1'b1;
    cyc(); cyc();

    // Held start key: exactly one LOAD, two cycles after the first sampled high.
    start_key = 1'b1;
    loads = 0;
    load_at = -1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (level_load === 1'b1) begin loads++; load_at = i; end
      if (i == 0) chk("start_idle", 32'(game_state), 0);
      if (i == 1) begin
        chk("start_load", 32'(game_state), 1);
        chk("start_lives", 32'(lives), 3);
        chk("start_level", 32'(level), 1);
      end
      if (i == 2) begin
        chk("start_play", 32'(game_state), 2);
        chk("start_freeze", 32'(freeze_motion), 0);
        chk("start_invul", 32'(player_invulnerable), 1);
      end
    end
    start_key = 1'b0;
    chk("start_load_count", 32'(loads), 1);
    chk("start_load_at", 32'(load_at), 1);

    frames(59);
    chk("invul_59", 32'(player_invulnerable), 1);
    frames(1);
    chk("invul_60", 32'(player_invulnerable), 0);

    // Long hit: one life lost, respawn on level 1, not re-accepted after LOAD.
    player_hit = 1'b1;
    cyc();
    chk("hit1_state", 32'(game_state), 3);
    chk("hit1_lives", 32'(lives), 2);
    chk("hit1_lost", 32'(life_lost), 1);
    cyc();
    chk("hit1_lost_clr", 32'(life_lost), 0);
    frames(44);
    chk("hit1_dying44", 32'(game_state), 3);
    last_frame();
    chk("hit1_respawn", 32'(game_state), 1);
    chk("hit1_respawn_ld", 32'(level_load), 1);
    cyc();
    chk("hit1_play", 32'(game_state), 2);
    chk("hit1_level", 32'(level), 1);
    repeat (410) cyc();
    player_hit = 1'b0;
    chk("hit1_still_play", 32'(game_state), 2);
    chk("hit1_lost_cnt", 32'(lost_cnt), 1);
    chk("hit1_lives_hold", 32'(lives), 2);

    // Two more hits lead to GAME_OVER.
    frames(60);
    player_hit = 1'b1; cyc(); player_hit = 1'b0;
    chk("hit2_lives", 32'(lives), 1);
    frames(44);
    last_frame();
    chk("hit2_load", 32'(game_state), 1);
    cyc();
    frames(60);
    player_hit = 1'b1; cyc(); player_hit = 1'b0;
    chk("hit3_state", 32'(game_state), 3);
    chk("hit3_lives", 32'(lives), 0);
    frames(44);
    chk("hit3_dying", 32'(game_state), 3);
    last_frame();
    chk("gameover_state", 32'(game_state), 5);
    chk("gameover_lives", 32'(lives), 0);
    chk("gameover_freeze", 32'(freeze_motion), 1);
    frames(3);
    chk("gameover_hold", 32'(game_state), 5);
    chk("gameover_lost_cnt", 32'(lost_cnt), 3);

    start_key = 1'b1; cyc(); cyc();
    chk("newgame_load", 32'(game_state), 1);
    chk("newgame_lives", 32'(lives), 3);
    chk("newgame_level", 32'(level), 1);
    start_key = 1'b0;
    cyc();
    chk("newgame_play", 32'(game_state), 2);

    for (int i = 0; i < 6; i++) begin
      start_key = tbl[i].start;
      player_hit = tbl[i].hit;
      door = tbl[i].door;
      pup = tbl[i].pup;
      enemies = tbl[i].enem;
      cyc();
      chk($sformatf("vec%0d_state", i), 32'(game_state), 32'(tbl[i].st));
      chk($sformatf("vec%0d_lives", i), 32'(lives), 32'(tbl[i].lv));
      chk($sformatf("vec%0d_level", i), 32'(level), 32'(tbl[i].lvl));
      chk($sformatf("vec%0d_invul", i), 32'(player_invulnerable), 32'(tbl[i].inv));
      chk($sformatf("vec%0d_freeze", i), 32'(freeze_motion), 32'(tbl[i].frz));
      chk($sformatf("vec%0d_load", i), 32'(level_load), 32'(tbl[i].ld));
      chk($sformatf("vec%0d_lost", i), 32'(life_lost), 32'(tbl[i].lost));
    end
    start_key = 1'b0; player_hit = 1'b0; door = 1'b0; pup = 1'b0;

    frames(89);
    chk("clear1_89", 32'(game_state), 4);
    last_frame();
    chk("clear1_load", 32'(game_state), 1);
    chk("clear1_level", 32'(level), 2);
    cyc();
    chk("clear1_play", 32'(game_state), 2);

    // Simultaneous hit and valid door: hit wins, level unchanged.
    frames(60);
    chk("lvl2_invul_end", 32'(player_invulnerable), 0);
    player_hit = 1'b1; door = 1'b1; enemies = 2'd0;
    cyc();
    player_hit = 1'b0; door = 1'b0;
    chk("hitdoor_state", 32'(game_state), 3);
    chk("hitdoor_lives", 32'(lives), 2);
    chk("hitdoor_level", 32'(level), 2);
    chk("hitdoor_lost", 32'(life_lost), 1);
    frames(44);
    last_frame();
    chk("hitdoor_respawn_lvl", 32'(level), 2);
    cyc();

    // Power-up at invulnerability count 5 reloads to 60 and masks hits.
    frames(55);
    chk("pup_before", 32'(player_invulnerable), 1);
    pup = 1'b1; cyc(); pup = 1'b0;
    player_hit = 1'b1; repeat (10) cyc(); player_hit = 1'b0;
    chk("pup_hit_state", 32'(game_state), 2);
    chk("pup_hit_lives", 32'(lives), 2);
    frames(59);
    chk("pup_59", 32'(player_invulnerable), 1);
    frames(1);
    chk("pup_60", 32'(player_invulnerable), 0);

    door = 1'b1; cyc(); door = 1'b0;
    chk("clear2_state", 32'(game_state), 4);
    frames(89);
    last_frame();
    chk("win_state", 32'(game_state), 6);
    chk("win_level", 32'(level), 2);
    chk("win_lives", 32'(lives), 2);
    chk("win_freeze", 32'(freeze_motion), 1);

    start_key = 1'b1; cyc(); cyc(); start_key = 1'b0;
    chk("win_newgame_load", 32'(game_state), 1);
    chk("win_newgame_level", 32'(level), 1);
    cyc();
    door = 1'b1; cyc(); door = 1'b0;
    chk("clear3_state", 32'(game_state), 4);
    frames(40);
    #2 resetN = 1'b0;
    #1;
    chk_reset("midclear_rst");
    cyc();
    resetN = 1'b1;
    cyc();
    chk("post_rst_idle", 32'(game_state), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_flow_sequencer.md
# game_flow_sequencer

Top-level game-state sequencer for Bomber Man. It consumes the per-pixel collision indications from the collision controller (player hit, player on door idol, power-up pickup) plus the start key. It sequences level load, play, death, level clear, game over and win. It owns lives, level number and the player invulnerability window that feeds back into the collision controller's hit qualification.

## Interface
- LIVES_INIT, 3: lives loaded at game start (1..7)
- LEVEL_MAX, 8: last level; clearing it wins the game (1..15)
- INVULN_FRAMES, 60: frames of invulnerability after every level load and after a power-up (1..255)
- DYING_FRAMES, 45: frames frozen after a hit (1..255)
- CLEAR_FRAMES, 90: frames frozen after level clear (1..255)

- clk  in  1  system clock
- resetN  in  1  asynchronous, active-low reset
- startOfFrame  in  1  one-cycle pulse per frame (30 Hz)
- start_key  in  1  level signal from keypad, any length
- player_hit  in  1  player overlaps blast/enemy (level, many cycles per frame)
- player_door_idol  in  1  player overlaps door idol (level)
- collision_player_powerUp  in  1  player overlaps power-up (level)
- enemies_remaining  in  2  live enemy count from enemy blocks
- game_state  out  3  IDLE=0, LOAD=1, PLAY=2, DYING=3, CLEAR=4, GAME_OVER=5, WIN=6
- lives  out  3  remaining lives
- level  out  4  current level, 1-based while a game is running
- player_invulnerable  out  1  high while the invulnerability counter is non-zero
- freeze_motion  out  1  high in every state except PLAY
- level_load  out  1  one-cycle pulse; board/enemy blocks reinitialise
- life_lost  out  1  one-cycle pulse on accepted hit

## Operation
- All outputs are registered or decoded from registered state only. There are no combinational paths from inputs to outputs.
- start_key is registered and rising-edge detected to give start_rise. A held key produces one start_rise only.
- IDLE: on start_rise, lives<=LIVES_INIT, level<=1, go to LOAD.
- LOAD: lasts exactly one cycle, with level_load=1 for that cycle. The invulnerability counter loads INVULN_FRAMES. Next state is PLAY unconditionally.
- PLAY, hit: an accepted hit requires player_hit=1 and the invulnerability counter=0. On it:
  - lives<=lives-1 and life_lost pulses.
  - The timer loads DYING_FRAMES and the state goes to DYING.
- PLAY, door: if player_door_idol=1 and enemies_remaining=0, the timer loads CLEAR_FRAMES and the state goes to CLEAR. When enemies_remaining≠0, door contact is ignored.
- PLAY, priority: if a hit and a valid door event occur in the same cycle, the hit wins.
- PLAY, power-up: collision_player_powerUp=1 reloads the invulnerability counter to INVULN_FRAMES. It reloads and does not accumulate. It is ignored outside PLAY.
- Invulnerability counter: decrements on startOfFrame only in PLAY, and saturates at 0. It holds its value in all other states.
- DYING: the timer decrements on each startOfFrame. On the startOfFrame where timer=1:
  - If lives=0, go to GAME_OVER.
  - Otherwise go to LOAD (respawn on the same level).
- CLEAR: the timer counts the same way as in DYING. On expiry:
  - If level=LEVEL_MAX, go to WIN.
  - Otherwise level<=level+1 and go to LOAD.
- GAME_OVER and WIN: all values hold. On start_rise, behave exactly as IDLE (new game).
- start_rise is ignored in LOAD, PLAY, DYING and CLEAR.
- lives never underflows, because a hit with lives=1 leads to GAME_OVER. Level never exceeds LEVEL_MAX.

## Timing
- Reset (async, any state, including mid-DYING): game_state=IDLE, lives=0, level=0, counters=0, player_invulnerable=0, freeze_motion=1, level_load=0, life_lost=0, start edge register=0.
- start_key rises at cycle N (sampled) → start_rise at N+1 → game_state=LOAD at N+2 → PLAY at N+3.
- Accepted hit sampled at cycle N → game_state=DYING, lives decremented and life_lost=1 all at N+1. life_lost=0 at N+2.
- DYING and CLEAR each last exactly DYING_FRAMES/CLEAR_FRAMES startOfFrame pulses. The exit occurs the cycle after the final pulse.
- Invulnerability after LOAD covers exactly INVULN_FRAMES startOfFrame pulses in PLAY.
- A player_hit that stays high across the DYING→LOAD→PLAY sequence is not re-accepted, because the counter is non-zero on PLAY entry.
- Timer width is 8 bits and the invulnerability counter width is 8 bits.

## Test plan
- Reset, then start_key held high for 10 cycles → exactly one LOAD. Then level=1, lives=3, level_load high for 1 cycle, player_invulnerable=1 for 60 frames, then 0.
- In PLAY after invulnerability ends, player_hit held for 500 cycles → single life_lost, lives=2, DYING for 45 frames, LOAD, PLAY with level=1.
- Three accepted hits → after the third DYING period, game_state=GAME_OVER and lives=0. Then start_key → lives=3, level=1, LOAD.
- player_door_idol with enemies_remaining=1 → stays in PLAY. With enemies_remaining=0 → CLEAR for 90 frames, then level=2 and LOAD. Simultaneous hit+door → DYING and level unchanged.
- Power-up at invulnerability count 5 → counter back to 60. player_hit during that window → ignored.
- LEVEL_MAX=2: clear level 1 and level 2 → game_state=WIN. resetN pulsed mid-CLEAR → IDLE with all outputs at their reset values.
